// File: rtl/rfBlackWidowPkg.sv
// Shared memory-op types for the Black Widow core: request/response records,
// function codes and memory-queue defaults.
package rfBlackWidowPkg;

  localparam int TID_W         = 4;
  localparam int DEF_MAX_OUTST = 4;

  typedef enum logic [1:0] {
    MR_LOAD  = 2'd0,
    MR_LOADZ = 2'd1,
    MR_STORE = 2'd2
  } mem_func_e;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    mem_func_e        func;
    logic [1:0]       sz;
    logic [31:0]      adr;
    logic [31:0]      dat;
  } MemoryRequest;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    mem_func_e        func;
    logic [31:0]      dat;
  } MemoryResponse;

  // Smallest power of two >= n (and >= 2), so a FIFO can wrap on pointer MSBs.
  function automatic int pow2ceil(input int n);
    int p;
    p = 2;
    while (p < n) p = p * 2;
    return p;
  endfunction

endpackage

// File: rtl/bw_mem_queue_if.sv
// Pipeline-side and BIU-side signals of the memory queue.
interface bw_mem_queue_if;
  import rfBlackWidowPkg::*;

  // biu_req_o/biu_req_v_o: a transfer happens on a rising edge where valid and
  // ready are both high; while valid && !ready the payload is held unchanged.
  logic          req_wr_i;
  MemoryRequest  req_i;
  logic          req_full_o;
  logic          req_wack_o;
  MemoryRequest  biu_req_o;
  logic          biu_req_v_o;
  logic          biu_req_rdy_i;
  MemoryResponse biu_rsp_i;
  logic          biu_rsp_v_i;
  logic          rsp_rd_i;
  MemoryResponse rsp_o;
  logic          rsp_v_o;
  logic          rsp_empty_o;
  logic [3:0]    outst_o;
  logic          ovf_o;
  logic          tid_err_o;

  modport slave (
    input  req_wr_i, req_i, biu_req_rdy_i, biu_rsp_i, biu_rsp_v_i, rsp_rd_i,
    output req_full_o, req_wack_o, biu_req_o, biu_req_v_o, rsp_o, rsp_v_o,
           rsp_empty_o, outst_o, ovf_o, tid_err_o
  );

  modport master (
    output req_wr_i, req_i, biu_req_rdy_i, biu_rsp_i, biu_rsp_v_i, rsp_rd_i,
    input  req_full_o, req_wack_o, biu_req_o, biu_req_v_o, rsp_o, rsp_v_o,
           rsp_empty_o, outst_o, ovf_o, tid_err_o
  );
endinterface

// File: rtl/bw_sync_fifo.sv
// Generic synchronous FIFO; full is evaluated before any same-cycle pop.
module bw_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr, do_rd;

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wptr[AW-1:0]] <= din;
  end

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign dout  = mem[rptr[AW-1:0]];
endmodule

// File: rtl/bw_mem_queue.sv
// Memory-op decoupling queue: in-order request issue to the BIU with an
// outstanding limit, and a response FIFO popped by the load-check logic.
module bw_mem_queue
  import rfBlackWidowPkg::*;
#(
  parameter int REQ_DEPTH = 8,
  parameter int RSP_DEPTH = 8,
  parameter int MAX_OUTST = DEF_MAX_OUTST
) (
  input logic            clk_i,
  input logic            rst_i,
  bw_mem_queue_if.slave  bus
);
  localparam int TID_DEPTH = pow2ceil(MAX_OUTST);
  localparam int TAW       = $clog2(TID_DEPTH);

  MemoryRequest             req_head;
  MemoryResponse            rsp_head;
  logic [TID_W-1:0]         tid_head;
  logic                     req_empty, req_full;
  logic                     rsp_empty, rsp_full;
  logic                     tid_empty, tid_full;
  logic [$clog2(REQ_DEPTH):0] req_count;
  logic [$clog2(RSP_DEPTH):0] rsp_count;
  logic [TAW:0]             tid_count;
  logic                     issue;
  logic                     unused_status;

  bw_sync_fifo #(.WIDTH($bits(MemoryRequest)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr(bus.req_wr_i), .rd(issue), .din(bus.req_i), .dout(req_head),
    .full(req_full), .empty(req_empty), .count(req_count)
  );

  bw_sync_fifo #(.WIDTH($bits(MemoryResponse)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr(bus.biu_rsp_v_i), .rd(bus.rsp_rd_i), .din(bus.biu_rsp_i), .dout(rsp_head),
    .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
  );

  // Occupancy of the issued-tid FIFO is the outstanding count: a response at
  // zero outstanding finds it empty, so the decrement is blocked for free.
  bw_sync_fifo #(.WIDTH(TID_W), .DEPTH(TID_DEPTH)) u_tid_fifo (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr(issue), .rd(bus.biu_rsp_v_i), .din(req_head.tid), .dout(tid_head),
    .full(tid_full), .empty(tid_empty), .count(tid_count)
  );

  assign unused_status = ^{req_count, rsp_count, tid_full};

  assign bus.biu_req_v_o = !req_empty && (int'(tid_count) < MAX_OUTST);
  assign bus.biu_req_o   = req_head;
  assign issue           = bus.biu_req_v_o && bus.biu_req_rdy_i;
  assign bus.req_full_o  = req_full;
  assign bus.rsp_empty_o = rsp_empty;
  assign bus.outst_o     = 4'(tid_count);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus.req_wack_o <= 1'b0;
      bus.rsp_o      <= '0;
      bus.rsp_v_o    <= 1'b0;
      bus.ovf_o      <= 1'b0;
      bus.tid_err_o  <= 1'b0;
    end else begin
      bus.req_wack_o <= bus.req_wr_i && !req_full;
      if (bus.rsp_rd_i) begin
        if (!rsp_empty) begin
          bus.rsp_o   <= rsp_head;
          bus.rsp_v_o <= 1'b1;
        end else begin
          bus.rsp_v_o <= 1'b0;
        end
      end
      if (bus.biu_rsp_v_i && rsp_full) bus.ovf_o <= 1'b1;
      if (bus.biu_rsp_v_i && (tid_empty || (bus.biu_rsp_i.tid != tid_head)))
        bus.tid_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bw_mem_queue.sv
// Directed bench for bw_mem_queue: fill/drop, issue limit, response ordering,
// tid errors, overflow and mid-stream reset.
module tb_bw_mem_queue;
  import rfBlackWidowPkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bw_mem_queue_if bus();

  bw_mem_queue #(.REQ_DEPTH(8), .RSP_DEPTH(8), .MAX_OUTST(4)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic MemoryRequest mk_req(input int t);
    MemoryRequest r;
    r.tid  = 4'(t);
    r.func = (t % 2 == 1) ? MR_STORE : MR_LOAD;
    r.sz   = 2'd2;
    r.adr  = 32'h1000 + 32'(t * 4);
    r.dat  = 32'hA500 + 32'(t);
    return r;
  endfunction

  function automatic MemoryResponse mk_rsp(input int t);
    MemoryResponse r;
    r.tid  = 4'(t);
    r.func = MR_LOAD;
    r.dat  = 32'h100 + 32'(t);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.req_wr_i      = 1'b0;
    bus.req_i         = '0;
    bus.biu_req_rdy_i = 1'b0;
    bus.biu_rsp_i     = '0;
    bus.biu_rsp_v_i   = 1'b0;
    bus.rsp_rd_i      = 1'b0;
  endtask

  task automatic push(input int t);
    bus.req_wr_i = 1'b1;
    bus.req_i    = mk_req(t);
    tick();
    bus.req_wr_i = 1'b0;
  endtask

  task automatic respond(input int t);
    bus.biu_rsp_v_i = 1'b1;
    bus.biu_rsp_i   = mk_rsp(t);
    tick();
    bus.biu_rsp_v_i = 1'b0;
  endtask

  task automatic pop();
    bus.rsp_rd_i = 1'b1;
    tick();
    bus.rsp_rd_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_full"},  bus.req_full_o,  0);
    check({pfx, "_req_wack"},  bus.req_wack_o,  0);
    check({pfx, "_biu_req_v"}, bus.biu_req_v_o, 0);
    check({pfx, "_rsp_v"},     bus.rsp_v_o,     0);
    check({pfx, "_rsp_empty"}, bus.rsp_empty_o, 1);
    check({pfx, "_outst"},     bus.outst_o,     0);
    check({pfx, "_ovf"},       bus.ovf_o,       0);
    check({pfx, "_tid_err"},   bus.tid_err_o,   0);
    check({pfx, "_rsp_o"},     bus.rsp_o,       0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_iss;
    idle();
    rst_i = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_i = 1'b1;
    tick();

    // Fill the request FIFO with no BIU acceptance.
    bus.req_wr_i = 1'b1;
    bus.req_i    = mk_req(0);
    #1;
    check("no_bypass_v", bus.biu_req_v_o, 0);
    tick();
    bus.req_wr_i = 1'b0;
    check("wack_first", bus.req_wack_o, 1);
    check("head_visible", bus.biu_req_v_o, 1);
    for (int i = 1; i < 8; i++) begin
      push(i);
      check("wack_fill", bus.req_wack_o, 1);
    end
    check("full_after_8", bus.req_full_o, 1);
    push(8);
    check("wack_dropped", bus.req_wack_o, 0);
    check("full_still", bus.req_full_o, 1);
    check("head_req", bus.biu_req_o, mk_req(0));
    tick();
    check("head_held_v", bus.biu_req_v_o, 1);
    check("head_held", bus.biu_req_o, mk_req(0));

    // Issue until the outstanding limit stops it.
    exp_q = {4'd0, 4'd1, 4'd2, 4'd3};
    bus.biu_req_rdy_i = 1'b1;
    n_iss = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.biu_req_v_o) begin
        n_iss++;
        if (exp_q.size() > 0) check("issue_tid", bus.biu_req_o.tid, exp_q.pop_front());
      end
      tick();
    end
    check("issue_count", n_iss, 4);
    check("outst_limit", bus.outst_o, 4);
    check("v_at_limit", bus.biu_req_v_o, 0);
    check("not_full_after_issue", bus.req_full_o, 0);
    respond(0);
    check("outst_after_rsp", bus.outst_o, 3);
    check("v_after_rsp", bus.biu_req_v_o, 1);
    check("next_head_tid", bus.biu_req_o.tid, 4);
    tick();
    check("outst_reissue", bus.outst_o, 4);
    check("v_reissue", bus.biu_req_v_o, 0);
    bus.biu_req_rdy_i = 1'b0;

    // In-order responses, then pop them with a gap cycle between pulses.
    respond(1);
    respond(2);
    respond(3);
    check("inorder_tid_err", bus.tid_err_o, 0);
    check("inorder_outst", bus.outst_o, 1);
    check("rsp_not_empty", bus.rsp_empty_o, 0);
    exp_q = {4'd0, 4'd1, 4'd2, 4'd3};
    while (exp_q.size() > 0) begin
      logic [3:0] t;
      t = exp_q.pop_front();
      pop();
      check("pop_v", bus.rsp_v_o, 1);
      check("pop_rsp", bus.rsp_o, mk_rsp(int'(t)));
      tick();
      check("pop_v_hold", bus.rsp_v_o, 1);
    end
    check("rsp_empty_after_pops", bus.rsp_empty_o, 1);
    pop();
    check("pop_empty_clears_v", bus.rsp_v_o, 0);

    // Matching last response, then one with nothing outstanding.
    respond(4);
    check("match_no_err", bus.tid_err_o, 0);
    check("outst_zero", bus.outst_o, 0);
    respond(9);
    check("zero_outst_err", bus.tid_err_o, 1);
    check("outst_no_wrap", bus.outst_o, 0);
    tick();
    check("tid_err_sticky", bus.tid_err_o, 1);

    // Mid-stream reset with request, response and pop paths all active.
    pop();
    check("pre_rst_rsp_v", bus.rsp_v_o, 1);
    push(6);
    check("pre_rst_req_v", bus.biu_req_v_o, 1);
    rst_i = 1'b0;
    bus.req_wr_i = 1'b1;
    bus.req_i = mk_req(10);
    bus.biu_req_rdy_i = 1'b1;
    bus.biu_rsp_v_i = 1'b1;
    bus.biu_rsp_i = mk_rsp(4);
    bus.rsp_rd_i = 1'b1;
    tick();
    idle();
    check_reset_vals("midrst");
    rst_i = 1'b1;
    bus.biu_req_rdy_i = 1'b1;
    push(5);
    check("post_rst_wack", bus.req_wack_o, 1);
    check("post_rst_v", bus.biu_req_v_o, 1);
    check("post_rst_head", bus.biu_req_o, mk_req(5));
    tick();
    check("post_rst_outst", bus.outst_o, 1);
    check("post_rst_v_drained", bus.biu_req_v_o, 0);
    bus.biu_req_rdy_i = 1'b0;
    respond(5);
    check("post_rst_no_err", bus.tid_err_o, 0);
    check("post_rst_outst0", bus.outst_o, 0);

    // Out-of-order tid against the oldest issued.
    bus.biu_req_rdy_i = 1'b1;
    push(0);
    push(1);
    tick();
    bus.biu_req_rdy_i = 1'b0;
    check("mis_outst", bus.outst_o, 2);
    respond(2);
    check("mis_tid_err", bus.tid_err_o, 1);
    check("mis_outst_dec", bus.outst_o, 1);
    respond(1);
    check("mis_err_sticky", bus.tid_err_o, 1);
    check("mis_outst0", bus.outst_o, 0);

    // Response FIFO overflow, starting with an arrival+pop on an empty FIFO.
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    check("ovf_rst_err", bus.tid_err_o, 0);
    bus.biu_rsp_v_i = 1'b1;
    bus.biu_rsp_i = mk_rsp(0);
    bus.rsp_rd_i = 1'b1;
    tick();
    idle();
    check("arr_pop_no_bypass_v", bus.rsp_v_o, 0);
    check("arr_pop_queued", bus.rsp_empty_o, 0);
    for (int i = 1; i < 8; i++) respond(i);
    check("ovf_before", bus.ovf_o, 0);
    respond(8);
    check("ovf_set", bus.ovf_o, 1);
    for (int i = 0; i < 8; i++) begin
      pop();
      check("ovf_pop_v", bus.rsp_v_o, 1);
      check("ovf_pop_tid", bus.rsp_o.tid, i);
    end
    check("ovf_drained", bus.rsp_empty_o, 1);
    pop();
    check("ovf_lost_entry", bus.rsp_v_o, 0);
    check("ovf_sticky", bus.ovf_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
